img_window_fetch: RTL

//  Parametrised WINxWIN neighbourhood fetcher for local contrast enhancement.
//  On a start pulse it reads WIN*WIN pixels around a centre pixel from a single-port image BRAM.
//  The BRAM has 1-cycle read latency.
//  The pixels are packed into one flat window bus, then a done pulse is raised.

---
 rtl/img_window_fetch.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/img_window_fetch.sv
// img_window_fetch
//   Fetches a WIN x WIN pixel neighbourhood around a centre pixel (cx, cy)
//   from a single-port image BRAM that has a 1-cycle read latency. It issues
//   one read per cycle in row-major order and packs the returned pixels into
//   a flat window bus. Slot (r,c) sits at [(r*WIN+c)*PIX_W +: PIX_W]. After
//   the last pixel lands it raises a one-cycle window_fetched pulse.
//
//   Build option (macro WIN_CLAMP_EN):
//     undefined : the BRAM holds the pre-padded image, PAD_W = IMG_W+WIN-1
//                 pixels wide. addr = (cy+r)*PAD_W + (cx+c).
//     defined   : the BRAM holds the unpadded image, IMG_W pixels wide.
//                 Edge pixels are replicated by clamping the row and column
//                 into the image before the address is formed.
//   Timing, FSM and ports are the same in both builds.

module img_window_fetch #(
  parameter int WIN    = 45,
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 17,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [XW-1:0]            cx,
  input  logic [YW-1:0]            cy,
  output logic                     busy,
  output logic                     window_fetched,
  output logic [WIN*WIN*PIX_W-1:0] window,
  output logic                     err,
  output logic                     mem_ren,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [PIX_W-1:0]         mem_dout
);

  localparam int NSLOT = WIN * WIN;
  localparam int RW    = $clog2(WIN);
  localparam int SW    = $clog2(NSLOT);
  localparam int WB    = NSLOT * PIX_W;

  localparam logic [RW-1:0] C_LAST = RW'(WIN - 1);
  localparam logic [SW-1:0] N_LAST = SW'(NSLOT - 1);

`ifdef WIN_CLAMP_EN
  localparam int HALF = (WIN - 1) / 2;
  localparam logic [ADDR_W-1:0]        ROW_STRIDE = ADDR_W'(IMG_W);
  localparam logic signed [XW+1:0]     COL_MIN    = '0;
  localparam logic signed [XW+1:0]     COL_MAX    = (XW+2)'(IMG_W - 1);
  localparam logic signed [XW+1:0]     HALF_X     = (XW+2)'(HALF);
  localparam logic signed [YW+1:0]     ROW_MIN    = '0;
  localparam logic signed [YW+1:0]     ROW_MAX    = (YW+2)'(IMG_H - 1);
  localparam logic signed [YW+1:0]     HALF_Y     = (YW+2)'(HALF);
`else
  localparam int PAD_W = IMG_W + WIN - 1;
  localparam logic [ADDR_W-1:0]        ROW_STRIDE = ADDR_W'(PAD_W);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     cx_q, cx_d;
  logic [YW-1:0]     cy_q, cy_d;
  logic [RW-1:0]     r_q, r_d;
  logic [RW-1:0]     c_q, c_d;
  logic [SW-1:0]     n_q, n_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              cap_vld_q;
  logic [SW-1:0]     cap_n_q;
  logic [WB-1:0]     win_q, win_d;
  logic              coords_ok;

  // BRAM address of window element (r,c) around centre (x,y).
  function automatic logic [ADDR_W-1:0] calc_addr(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y,
    input logic [RW-1:0] r,
    input logic [RW-1:0] c
  );
`ifdef WIN_CLAMP_EN
    logic signed [XW+1:0] col;
    logic signed [YW+1:0] row;
    col = $signed({2'b00, x}) + $signed((XW+2)'(c)) - HALF_X;
    row = $signed({2'b00, y}) + $signed((YW+2)'(r)) - HALF_Y;
    if (col < COL_MIN)      col = COL_MIN;
    else if (col > COL_MAX) col = COL_MAX;
    if (row < ROW_MIN)      row = ROW_MIN;
    else if (row > ROW_MAX) row = ROW_MAX;
    calc_addr = ADDR_W'(unsigned'(row)) * ROW_STRIDE + ADDR_W'(unsigned'(col));
`else
    calc_addr = (ADDR_W'(y) + ADDR_W'(r)) * ROW_STRIDE + ADDR_W'(x) + ADDR_W'(c);
`endif
  endfunction

  // A start is only honoured when the centre lies inside the image.
  assign coords_ok = ({1'b0, cx} < (XW+1)'(IMG_W)) && ({1'b0, cy} < (YW+1)'(IMG_H));

  // Next-state logic: accept/reject starts, walk the issue counters, form the next address.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    r_d     = r_q;
    c_d     = c_q;
    n_d     = n_q;
    ren_d   = 1'b0;
    addr_d  = addr_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (coords_ok) begin
            state_d = S_READ;
            cx_d    = cx;
            cy_d    = cy;
            r_d     = '0;
            c_d     = '0;
            n_d     = '0;
            ren_d   = 1'b1;
            addr_d  = calc_addr(cx, cy, '0, '0);
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_READ: begin
        if (n_q == N_LAST) begin
          state_d = S_DRAIN;
        end else begin
          // NOTE: blocking assignments in combinational logic, so r_d/c_d below
          // already hold the advanced counters when the address is formed.
          if (c_q == C_LAST) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
          n_d    = n_q + 1'b1;
          ren_d  = 1'b1;
          addr_d = calc_addr(cx_q, cy_q, r_d, c_d);
        end
      end

      S_DRAIN: state_d = S_DONE;

      default: state_d = S_IDLE;
    endcase
  end

  // Capture: returning read data lands in the slot recorded one cycle earlier.
  always_comb begin
    win_d = win_q;
    if (cap_vld_q) begin
      win_d[int'(cap_n_q) * PIX_W +: PIX_W] = mem_dout;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q   <= S_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      r_q       <= '0;
      c_q       <= '0;
      n_q       <= '0;
      ren_q     <= 1'b0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_n_q   <= '0;
      // NOTE: the window store is a wide register, not a RAM, so it can and
      // must be cleared on reset; consumers see an all-zero window after reset.
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      r_q       <= r_d;
      c_q       <= c_d;
      n_q       <= n_d;
      ren_q     <= ren_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      cap_vld_q <= ren_q;
      cap_n_q   <= n_q;
      win_q     <= win_d;
    end
  end

  assign busy           = (state_q == S_READ) || (state_q == S_DRAIN);
  assign window_fetched = (state_q == S_DONE);
  assign err            = err_q;
  assign mem_ren        = ren_q;
  assign mem_addr       = addr_q;
  assign window         = win_q;

endmodule
